// File: rtl/srl_data_vld_prog.sv
// Programmable-delay data/valid pipeline built on a circular buffer.
// Delay is runtime-selectable (1..MAX_DELAY); delay changes suppress dout_vld while settling.
module srl_data_vld_prog #(
    parameter int  DATA_WIDTH = 18,
    parameter int  MAX_DELAY  = 32,
    localparam int DELAY_W    = $clog2(MAX_DELAY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [DELAY_W-1:0]    delay,
    input  logic                  din_vld,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  dout_vld,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  delay_err,
    output logic                  settling
);

    localparam int AW = $clog2(MAX_DELAY);

    function automatic logic [DELAY_W-1:0] clamp_delay(input logic [DELAY_W-1:0] x);
        if (x == '0)
            return DELAY_W'(1);
        else if (x > DELAY_W'(MAX_DELAY))
            return DELAY_W'(MAX_DELAY);
        else
            return x;
    endfunction

    function automatic logic delay_out_of_range(input logic [DELAY_W-1:0] x);
        return (x == '0) || (x > DELAY_W'(MAX_DELAY));
    endfunction

    logic [DATA_WIDTH-1:0] mem [MAX_DELAY];
    logic [MAX_DELAY-1:0]  vld_mem;
    logic [AW-1:0]         wr_ptr;
    logic [DELAY_W-1:0]    d_act;
    logic [DELAY_W-1:0]    settle_cnt;

    logic [DELAY_W-1:0]    d_new;
    logic                  err_new;
    logic [AW+1:0]         rd_sum;
    logic [AW-1:0]         rd_addr;
    logic                  rd_vld_p0;
    logic [DATA_WIDTH-1:0] rd_data_p0;

    // Read stage: slot written D-1 ce-cycles ago; D=1 bypasses straight from the input
    always_comb begin
        d_new   = clamp_delay(delay);
        err_new = delay_out_of_range(delay);
        rd_sum  = (AW+2)'(wr_ptr) + (AW+2)'(MAX_DELAY + 1) - (AW+2)'(d_act);
        if (rd_sum >= (AW+2)'(MAX_DELAY))
            rd_sum = rd_sum - (AW+2)'(MAX_DELAY);
        rd_addr = AW'(rd_sum);
        if (d_act == DELAY_W'(1)) begin
            rd_vld_p0  = din_vld;
            rd_data_p0 = din;
        end else begin
            rd_vld_p0  = vld_mem[rd_addr];
            rd_data_p0 = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (ce && !rst)
            mem[wr_ptr] <= din;
    end

    // Output stage: registered outputs, valid masked while a delay change settles
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            vld_mem    <= '0;
            dout_vld   <= 1'b0;
            dout       <= '0;
            settling   <= 1'b0;
            settle_cnt <= '0;
            d_act      <= d_new;
            delay_err  <= err_new;
        end else if (ce) begin
            vld_mem[wr_ptr] <= din_vld;
            wr_ptr          <= (wr_ptr == AW'(MAX_DELAY - 1)) ? '0 : wr_ptr + AW'(1);
            dout            <= rd_data_p0;
            delay_err       <= err_new;
            if (d_new != d_act) begin
                d_act      <= d_new;
                settle_cnt <= d_new;
                settling   <= 1'b1;
                dout_vld   <= 1'b0;
            end else if (settling) begin
                // settling stays high for exactly D cycles: drops on the edge the count hits 0
                settle_cnt <= settle_cnt - DELAY_W'(1);
                settling   <= (settle_cnt != DELAY_W'(1));
                dout_vld   <= rd_vld_p0 && (settle_cnt == DELAY_W'(1));
            end else begin
                dout_vld <= rd_vld_p0;
            end
        end
    end

endmodule

// File: tb/tb_srl_data_vld_prog.sv
// Directed bench for srl_data_vld_prog: latency, boundaries, stalls, delay changes, flush.
module tb_srl_data_vld_prog;

    localparam int DW = $clog2(33);

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [DW-1:0] delay;
    logic          din_vld;
    logic [17:0]   din;
    logic          dout_vld;
    logic [17:0]   dout;
    logic          delay_err;
    logic          settling;

    int n_chk  = 0;
    int n_pass = 0;

    srl_data_vld_prog #(.DATA_WIDTH(18), .MAX_DELAY(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .delay     (delay),
        .din_vld   (din_vld),
        .din       (din),
        .dout_vld  (dout_vld),
        .dout      (dout),
        .delay_err (delay_err),
        .settling  (settling)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [DW-1:0] d, input logic ce_v);
        rst = 1'b1; ce = ce_v; delay = d; din_vld = 1'b0; din = '0;
        tick();
        rst = 1'b0; ce = 1'b1;
    endtask

    // Stream din=k*7+3 with din_vld=1; sample k emerges after edge k+D-1
    task automatic stream_check(input int d_req, input int d_eff, input logic err, input int n);
        do_reset(DW'(d_req), 1'b1);
        check("rst_vld", 32'(dout_vld), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_settling", 32'(settling), 32'd0);
        check("rst_err", 32'(delay_err), 32'(err));
        for (int k = 0; k < n; k++) begin
            din = 18'(k * 7 + 3); din_vld = 1'b1;
            tick();
            check("stream_err", 32'(delay_err), 32'(err));
            check("stream_settling", 32'(settling), 32'd0);
            if (k >= d_eff - 1) begin
                check("stream_vld", 32'(dout_vld), 32'd1);
                check("stream_dout", 32'(dout), 32'((k - d_eff + 1) * 7 + 3));
            end else begin
                check("stream_vld_early", 32'(dout_vld), 32'd0);
            end
        end
    endtask

    initial begin
        logic [63:0]   ce_pat;
        logic [5:0]    sp;
        logic          pv, ps, pe;
        logic [17:0]   pd;
        logic          c, ev;
        int            j;

        rst = 1'b1; ce = 1'b0; delay = DW'(5); din_vld = 1'b0; din = '0;

        stream_check(5, 5, 1'b0, 100);
        stream_check(1, 1, 1'b0, 10);
        stream_check(32, 32, 1'b0, 40);
        stream_check(0, 1, 1'b1, 10);
        stream_check(40, 32, 1'b1, 40);

        // Clock-enable stalls at delay 7; during ce=0 the delay port is wiggled and must be ignored
        ce_pat = 64'hB4E1_59A7_3C2D_96F0;
        do_reset(DW'(7), 1'b1);
        j = 0;
        pv = dout_vld; pd = dout; ps = settling; pe = delay_err;
        for (int i = 0; i < 90; i++) begin
            c = ce_pat[i % 64];
            ce = c;
            delay = c ? DW'(7) : DW'(3);
            din_vld = c;
            din = c ? 18'(100 + j) : 18'h3ffff;
            tick();
            if (c) begin
                check("stall_settling", 32'(settling), 32'd0);
                if (j >= 6) begin
                    check("stall_vld", 32'(dout_vld), 32'd1);
                    check("stall_dout", 32'(dout), 32'(100 + j - 6));
                end else begin
                    check("stall_vld_early", 32'(dout_vld), 32'd0);
                end
                j++;
            end else begin
                check("hold_vld", 32'(dout_vld), 32'(pv));
                check("hold_dout", 32'(dout), 32'(pd));
                check("hold_settling", 32'(settling), 32'(ps));
                check("hold_err", 32'(delay_err), 32'(pe));
            end
            pv = dout_vld; pd = dout; ps = settling; pe = delay_err;
        end
        ce = 1'b1;

        // Delay change 10 -> 3, then 3 -> 12 overridden by 8 on the second settle cycle
        do_reset(DW'(10), 1'b1);
        for (int k = 0; k < 20; k++) begin
            din = 18'(200 + k); din_vld = 1'b1;
            tick();
        end
        check("chg_steady_vld", 32'(dout_vld), 32'd1);
        check("chg_steady_dout", 32'(dout), 32'd210);
        for (int k = 20; k < 28; k++) begin
            delay = DW'(3); din = 18'(200 + k);
            tick();
            if (k < 23) begin
                check("chg3_settling", 32'(settling), 32'd1);
                check("chg3_vld", 32'(dout_vld), 32'd0);
            end else begin
                check("chg3_settling_end", 32'(settling), 32'd0);
                check("chg3_vld_end", 32'(dout_vld), 32'd1);
                check("chg3_dout", 32'(dout), 32'(200 + k - 2));
            end
        end
        for (int k = 28; k < 46; k++) begin
            delay = (k == 28) ? DW'(12) : DW'(8);
            din = 18'(200 + k);
            tick();
            if (k <= 36) begin
                check("chg8_settling", 32'(settling), 32'd1);
                check("chg8_vld", 32'(dout_vld), 32'd0);
            end else begin
                check("chg8_settling_end", 32'(settling), 32'd0);
                check("chg8_vld_end", 32'(dout_vld), 32'd1);
                check("chg8_dout", 32'(dout), 32'(200 + k - 7));
            end
        end

        // Reset flush with ce low: in-flight valids must never reach dout_vld
        do_reset(DW'(20), 1'b1);
        for (int k = 0; k < 19; k++) begin
            din = 18'(300 + k); din_vld = 1'b1; delay = DW'(20);
            tick();
        end
        check("flush_pre_vld", 32'(dout_vld), 32'd0);
        rst = 1'b1; ce = 1'b0; din_vld = 1'b1; din = 18'h155;
        tick();
        check("flush_rst_vld", 32'(dout_vld), 32'd0);
        check("flush_rst_dout", 32'(dout), 32'd0);
        check("flush_rst_settling", 32'(settling), 32'd0);
        rst = 1'b0; ce = 1'b1; din_vld = 1'b0;
        for (int k = 0; k < 22; k++) begin
            din = 18'(500 + k);
            tick();
            check("flush_vld", 32'(dout_vld), 32'd0);
        end

        // Sparse valids at delay 4; reset also changes the delay 20 -> 4 with no settling
        sp = 6'b011001;
        do_reset(DW'(4), 1'b1);
        check("sparse_rst_settling", 32'(settling), 32'd0);
        for (int k = 0; k < 16; k++) begin
            din_vld = (k < 12) ? sp[k % 6] : 1'b0;
            din = 18'(400 + k); delay = DW'(4);
            tick();
            ev = (k >= 3 && k - 3 < 12) ? sp[(k - 3) % 6] : 1'b0;
            check("sparse_vld", 32'(dout_vld), 32'(ev));
            if (ev)
                check("sparse_dout", 32'(dout), 32'(400 + k - 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
